// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache access controller.
// Covers the controller state encoding, access width codes, byte-strobe
// patterns, and the width legality helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_LO_HALF = 4'b0011;
  localparam logic [3:0] STRB_HI_HALF = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Only byte, half and word accesses reach the bus; anything else is a no-op.
  function automatic logic width_ok(input logic [2:0] width);
    return (width == W_BYTE) || (width == W_HALF) || (width == W_WORD);
  endfunction

endpackage

// File: rtl/dcache_access_ctrl_if.sv
// Word-aligned data memory bus: a valid/ready request channel plus a
// read-response channel (rvalid arrives at least one cycle after acceptance).
interface dcache_access_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/dcache_lane_align.sv
// Byte-lane steering between the right-justified pipeline view and the
// word-aligned bus: store strobes/replication and load extract/extension.
// Half offsets use off[1] only and word accesses ignore the offset, so a
// misaligned access that reaches this block is silently masked.
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = bus_rdata[8*gi +: 8];
  end

  assign sel_byte = rd_byte[off];
  assign sel_half = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  // Select strobes, replicated store data and extended load data by width.
  always_comb begin
    wstrb      = STRB_WORD;
    lane_wdata = wdata;
    rdata_ext  = bus_rdata;
    case (width)
      W_BYTE: begin
        wstrb      = STRB_BYTE0 << off;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign & sel_byte[7]}}, sel_byte};
      end
      W_HALF: begin
        wstrb      = off[1] ? STRB_HI_HALF : STRB_LO_HALF;
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign & sel_half[15]}}, sel_half};
      end
      default: begin
        wstrb      = STRB_WORD;
        lane_wdata = wdata;
        rdata_ext  = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dcache_access_ctrl.sv
// MEM-stage data access controller: turns one load or store into a single
// word-aligned bus transaction and stalls the pipeline until it completes.
// Optional build macro DCACHE_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the bus and complete immediately with misalign=1.
module dcache_access_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic [2:0]        rwidth,
  input  logic              rsign,
  input  logic              wen,
  input  logic [2:0]        wwidth,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  dcache_access_ctrl_if.master bus
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        width_reg;
  logic              sign_reg;
  logic              we_reg;
  logic [31:0]       wdata_reg;
  logic              bus_valid_reg;
  logic              done_reg;
  logic              misalign_reg;
  logic [31:0]       rdata_reg;

  logic              req_load;
  logic              req_store;
  logic              req_legal;
  logic [2:0]        req_width;
  logic              req_misalign;

  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_wdata;
  logic [31:0]       rdata_ext;

  // A load wins over a simultaneous store; illegal widths make no request.
  assign req_load  = ren && width_ok(rwidth);
  assign req_store = wen && width_ok(wwidth) && !req_load;
  assign req_legal = req_load || req_store;
  assign req_width = req_load ? rwidth : wwidth;

`ifdef DCACHE_MISALIGN_TRAP_EN
  assign req_misalign = ((req_width == W_HALF) && addr[0]) ||
                        ((req_width == W_WORD) && (addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  dcache_lane_align u_lane_align (
    .width      (width_reg),
    .off        (addr_reg[1:0]),
    .sign       (sign_reg),
    .wdata      (wdata_reg),
    .bus_rdata  (bus.bus_rdata),
    .wstrb      (lane_wstrb),
    .lane_wdata (lane_wdata),
    .rdata_ext  (rdata_ext)
  );

  // Access sequencer: latch request, hold the bus request until accepted,
  // wait for the read response, then pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      width_reg     <= '0;
      sign_reg      <= 1'b0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      bus_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      misalign_reg  <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_legal) begin
            addr_reg  <= addr;
            width_reg <= req_width;
            sign_reg  <= req_load & rsign;
            we_reg    <= req_store;
            wdata_reg <= wdata;
            if (req_misalign) begin
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              misalign_reg <= 1'b1;
            end else begin
              state_reg     <= REQ;
              bus_valid_reg <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            bus_valid_reg <= 1'b0;
            if (we_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.bus_rvalid) begin
            rdata_reg <= rdata_ext;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg    <= IDLE;
          done_reg     <= 1'b0;
          misalign_reg <= 1'b0;
        end
        default: begin
          state_reg     <= IDLE;
          bus_valid_reg <= 1'b0;
          done_reg      <= 1'b0;
          misalign_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must rise in the request cycle itself, so it is decoded from inputs.
  assign stall = ((state_reg == IDLE) && req_legal) ||
                 (state_reg == REQ) || (state_reg == RESP);

  assign done     = done_reg;
  assign misalign = misalign_reg;
  assign rdata    = rdata_reg;

  assign bus.bus_valid = bus_valid_reg;
  assign bus.bus_we    = we_reg;
  assign bus.bus_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign bus.bus_wdata = lane_wdata;
  assign bus.bus_wstrb = lane_wstrb;

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Scoreboard bench for dcache_access_ctrl: expected bus transactions and
// completions are queued when a request is driven and compared when the
// DUT hands the request to the bus or pulses done.
module tb_dcache_access_ctrl;

  logic        clk;
  logic        rst;
  logic        ren;
  logic [2:0]  rwidth;
  logic        rsign;
  logic        wen;
  logic [2:0]  wwidth;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;

  dcache_access_ctrl_if #(.ADDR_W(32)) bus_if ();

  dcache_access_ctrl #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .rwidth   (rwidth),
    .rsign    (rsign),
    .wen      (wen),
    .wwidth   (wwidth),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .misalign (misalign),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
  } res_exp_t;

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  int          checks;
  int          failures;
  logic [31:0] last_rdata;
  int          txn_no;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic ok_width(input logic [2:0] w);
    return (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] w, input logic [1:0] off);
    case (w)
      3'd1: case (off)
              2'd0: return 4'b0001;
              2'd1: return 4'b0010;
              2'd2: return 4'b0100;
              default: return 4'b1000;
            endcase
      3'd2: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_lane(input logic [2:0] w, input logic [31:0] wd);
    case (w)
      3'd1: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'd2: return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] w, input logic [1:0] off,
                                           input logic s, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[off*8 +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (w)
      3'd1: return (s && b[7]) ? {24'hFFFFFF, b} : {24'h000000, b};
      3'd2: return (s && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
      default: return word;
    endcase
  endfunction

  // Drive one request, model its expected bus traffic and completion, and
  // play the memory side (ready after rdy_wait cycles, response rsp_wait
  // cycles after acceptance; junk rvalid pulses while the request waits).
  task automatic access(input logic r, input logic [2:0] rw, input logic rs,
                        input logic w, input logic [2:0] ww,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_wait, input int rsp_wait, input logic [31:0] resp);
    logic     is_load;
    logic     is_store;
    logic     legal;
    logic     trap;
    logic [2:0] wdt;
    bus_exp_t be;
    res_exp_t re;
    int       resp_at;
    int       limit;
    logic     done_seen;
    int       lat_seen;

    is_load  = r && ok_width(rw);
    is_store = !is_load && w && ok_width(ww);
    legal    = is_load || is_store;
    wdt      = is_load ? rw : ww;
    trap     = 1'b0;
`ifdef DCACHE_MISALIGN_TRAP_EN
    trap = legal && (((wdt == 3'd2) && a[0]) || ((wdt == 3'd4) && (a[1:0] != 2'b00)));
`endif
    if (legal) begin
      if (!trap) begin
        be.we    = is_store;
        be.addr  = {a[31:2], 2'b00};
        be.wdata = exp_lane(wdt, wd);
        be.wstrb = exp_strb(wdt, a[1:0]);
        bus_q.push_back(be);
      end
      re.rdata = (is_load && !trap) ? exp_load(wdt, a[1:0], rs, resp) : last_rdata;
      re.mis   = trap;
      re.lat   = trap ? 1 : (is_load ? rdy_wait + rsp_wait + 3 : rdy_wait + 2);
      res_q.push_back(re);
    end

    @(posedge clk); #1;
    ren = r; rwidth = rw; rsign = rs; wen = w; wwidth = ww; addr = a; wdata = wd;
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq("stall_req", {31'd0, stall}, {31'd0, legal});

    resp_at   = -1;
    limit     = legal ? 30 : 4;
    done_seen = 1'b0;
    lat_seen  = 0;
    for (int c = 1; c <= limit && !done_seen; c++) begin
      @(posedge clk); #1;
      ren = 1'b0; wen = 1'b0;
      bus_if.bus_ready  = (c - 1 >= rdy_wait);
      bus_if.bus_rvalid = (c == resp_at) || !bus_if.bus_ready;
      bus_if.bus_rdata  = (c == resp_at) ? resp : 32'hDEADBEEF;
      @(negedge clk);
      if (bus_if.bus_valid) begin
        if (bus_q.size() == 0) begin
          check_eq("bus_extra", {31'd0, bus_if.bus_valid}, 32'd0);
        end else begin
          be = bus_q[0];
          check_eq("bus_we", {31'd0, bus_if.bus_we}, {31'd0, be.we});
          check_eq("bus_addr", bus_if.bus_addr, be.addr);
          if (be.we) begin
            check_eq("bus_wdata", bus_if.bus_wdata, be.wdata);
            check_eq("bus_wstrb", {28'd0, bus_if.bus_wstrb}, {28'd0, be.wstrb});
          end
          if (bus_if.bus_ready) begin
            void'(bus_q.pop_front());
            if (!be.we) resp_at = c + 1 + rsp_wait;
          end
        end
      end
      if (done) begin
        done_seen = 1'b1;
        lat_seen  = c;
        if (res_q.size() == 0) begin
          check_eq("done_extra", {31'd0, done}, 32'd0);
        end else begin
          re = res_q.pop_front();
          check_eq("done_latency", c, re.lat);
          check_eq("rdata", rdata, re.rdata);
          check_eq("misalign", {31'd0, misalign}, {31'd0, re.mis});
          check_eq("stall_done", {31'd0, stall}, 32'd0);
          last_rdata = re.rdata;
        end
      end else if (legal) begin
        check_eq("stall_busy", {31'd0, stall}, 32'd1);
      end else begin
        check_eq("stall_noop", {31'd0, stall}, 32'd0);
      end
    end
    if (legal && !done_seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
      bus_q.delete();
      res_q.delete();
    end
    if (legal) check_eq("bus_q_empty", bus_q.size(), 32'd0);
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    txn_no++;
    $display("txn %0d: %s w=%0d addr=%h lat=%0d rdata=%h misalign=%0d",
             txn_no, is_load ? "load " : (is_store ? "store" : "noop "),
             wdt, a, lat_seen, rdata, misalign);
  endtask

  initial begin
    int rw_sel;
    logic [2:0] rnd_w;
    logic [31:0] rnd_a;
    logic rnd_ld;

    checks = 0; failures = 0; last_rdata = 32'd0; txn_no = 0;
    rst = 1'b1; ren = 1'b0; rwidth = 3'd0; rsign = 1'b0; wen = 1'b0; wwidth = 3'd0;
    addr = 32'd0; wdata = 32'd0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_bus_valid", {31'd0, bus_if.bus_valid}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);

    // Reset while waiting for a read response; a later stray rvalid is ignored.
    @(posedge clk); #1;
    ren = 1'b1; rwidth = 3'd4; addr = 32'h0000_7000;
    @(posedge clk); #1;
    ren = 1'b0; bus_if.bus_ready = 1'b1;
    @(negedge clk);
    check_eq("rr_req_valid", {31'd0, bus_if.bus_valid}, 32'd1);
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rr_resp_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("rr_idle_stall", {31'd0, stall}, 32'd0);
    check_eq("rr_idle_valid", {31'd0, bus_if.bus_valid}, 32'd0);
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq("rr_no_done", {31'd0, done}, 32'd0);
    check_eq("rr_rdata", rdata, 32'd0);
    $display("txn reset-during-resp: rdata=%h done=%0d", rdata, done);

    // Directed accesses.
    access(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'd0, 0, 0, 32'h8012_3456);
    check_eq("lb_signed", last_rdata, 32'hFFFF_FF80);
    access(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 32'h0000_2002, 32'd0, 0, 0, 32'h9ABC_1234);
    check_eq("lh_unsigned", rdata, 32'h0000_9ABC);
    access(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 32'h0000_3001, 32'h0000_00A5, 0, 0, 32'd0);
    access(1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 32'h0000_3104, 32'hCAFE_BABE, 3, 0, 32'd0);
    access(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 32'h0000_6000, 32'd0, 1, 2, 32'h1111_8001);
    access(1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 32'h0000_5000, 32'h1111_1111, 0, 0, 32'h55AA_55AA);
    access(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 32'h0000_5100, 32'd0, 0, 0, 32'd0);
    access(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 32'h0000_5200, 32'h0000_0001, 0, 0, 32'd0);
    access(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 32'h0000_5302, 32'h0000_BEEF, 0, 0, 32'd0);
    access(1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 32'h0000_4002, 32'd0, 0, 0, 32'hCAFE_F00D);

    // Random aligned loads and stores.
    for (int i = 0; i < 12; i++) begin
      rw_sel = $urandom_range(0, 2);
      rnd_w  = (rw_sel == 0) ? 3'd1 : ((rw_sel == 1) ? 3'd2 : 3'd4);
      rnd_a  = $urandom;
      if (rnd_w == 3'd2) rnd_a[0] = 1'b0;
      if (rnd_w == 3'd4) rnd_a[1:0] = 2'b00;
      rnd_ld = $urandom_range(0, 1) == 1;
      access(rnd_ld, rnd_w, $urandom_range(0, 1) == 1, !rnd_ld, rnd_w, rnd_a, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 1), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
